// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg: shared FSM state type, instruction size and default reset PC
// Contents:
//   state_t          - sequencer states RUN / FLUSH / HALT
//   INSN_BYTES       - byte stride between sequential instructions
//   DEFAULT_RESET_PC - default value of pc_redirect's RESET_PC parameter
package pc_redirect_pkg;
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    localparam logic [31:0] INSN_BYTES = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_redirect_branch_target.sv
// branch_target: combinational redirect-target adder for the EX-stage instruction
// Ports:
//   i_is_jalr - select register-relative (JALR) form instead of PC-relative
//   i_pc      - EX-stage PC
//   i_imm     - sign-extended immediate
//   i_rs1     - rs1 operand
//   o_target  - JALR: (rs1+imm) with bit 0 cleared; otherwise pc+imm (both wrap mod 2^32)
module branch_target (
    input  logic        i_is_jalr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1,
    output logic [31:0] o_target
);
    logic [31:0] w_jalr_sum;
    assign w_jalr_sum = i_rs1 + i_imm;
    assign o_target   = i_is_jalr ? (w_jalr_sum & ~32'h1) : (i_pc + i_imm);
endmodule

// File: rtl/pc_redirect.sv
// pc_redirect: fetch-PC sequencer with EX-stage redirect, flush control and misalignment halt
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   stall                    - hold the fetch PC (ignored in the cycle a redirect is accepted)
//   is_branch_ex, jump_taken - conditional branch in EX and its resolved condition
//   is_jal_ex, is_jalr_ex    - unconditional jumps in EX (JALR has priority)
//   pc_ex, imm_ex, rs1_ex    - operands for the redirect target
//   pc_if, pc_plus4_if       - fetch address and its sequential successor
//   flush_if_id, flush_id_ex - pipeline-register flush requests
//   redirect_valid           - one-cycle pulse on an accepted redirect
//   misalign_err             - sticky: a taken target had bit 1 set
//   redirect_count           - saturating count of accepted redirects
module pc_redirect
    import pc_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        is_branch_ex,
    input  logic        jump_taken,
    input  logic        is_jal_ex,
    input  logic        is_jalr_ex,
    input  logic [31:0] pc_ex,
    input  logic [31:0] imm_ex,
    input  logic [31:0] rs1_ex,
    output logic [31:0] pc_if,
    output logic [31:0] pc_plus4_if,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        redirect_valid,
    output logic        misalign_err,
    output logic [15:0] redirect_count
);
    state_t      r_state, w_next;
    logic [31:0] r_pc, w_pc_next, w_target, w_pc_plus4;
    logic        r_err;
    logic [15:0] r_count;
    logic        w_take, w_fi, w_fe, w_rv, w_err_set;

    branch_target u_target (
        .i_is_jalr (is_jalr_ex),
        .i_pc      (pc_ex),
        .i_imm     (imm_ex),
        .i_rs1     (rs1_ex),
        .o_target  (w_target)
    );

    assign w_take     = is_jalr_ex | is_jal_ex | (is_branch_ex & jump_taken);
    assign w_pc_plus4 = r_pc + INSN_BYTES;

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_fi      = 1'b0;
        w_fe      = 1'b0;
        w_rv      = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
            RUN: begin
                if (w_take && !w_target[1]) begin
                    w_pc_next = w_target;
                    w_fi      = 1'b1;
                    w_fe      = 1'b1;
                    w_rv      = 1'b1;
                    w_next    = FLUSH;
                end else if (w_take) begin
                    w_err_set = 1'b1;
                    w_next    = HALT;
                end else begin
                    w_pc_next = stall ? r_pc : w_pc_plus4;
                end
            end
            // IMEM returns the word fetched before the redirect took effect; drop it
            FLUSH: begin
                w_fi      = 1'b1;
                w_pc_next = stall ? r_pc : w_pc_plus4;
                w_next    = RUN;
            end
            HALT: begin
                w_fi = 1'b1;
                w_fe = 1'b1;
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_err   <= 1'b0;
            r_count <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_err_set) r_err <= 1'b1;
            if (w_rv && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        end
    end

    assign pc_if          = r_pc;
    assign pc_plus4_if    = w_pc_plus4;
    assign flush_if_id    = w_fi & ~rst;
    assign flush_id_ex    = w_fe & ~rst;
    assign redirect_valid = w_rv & ~rst;
    assign misalign_err   = r_err;
    assign redirect_count = r_count;
endmodule
